cdc_mcp_src: RTL

Source-domain (transmit) end of a multi-cycle-path (MCP) data crossing using toggle request/acknowledge. Accepts a word on a valid/ready handshake and holds it stable on mcp_data. After MCP_DELAY cycles it toggles mcp_req. It then waits for mcp_ack from the destination domain, brought in through an internal SYNC_DEPTH flop synchronizer, to match. Sits in the sending clock domain opposite the destination-side bit synchronizer and capture logic.

---
 rtl/cdc_pkg.sv | 13 +
 rtl/cdc_ack_sync.sv | 29 ++
 rtl/cdc_mcp_src.sv | 111 +++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared types and parameter floors for the MCP toggle-handshake crossing.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    WAIT_ACK = 2'd2
  } cdc_src_state_e;

  localparam int SYNC_DEPTH_MIN = 2;
  localparam int MCP_DELAY_MIN  = 1;

endpackage

// File: rtl/cdc_ack_sync.sv
// Flop-chain synchronizer for the returning ack toggle; SYNC_DEPTH cycles of latency.
module cdc_ack_sync
  import cdc_pkg::*;
#(
  parameter int SYNC_DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_DEPTH-1:0] r_chain;

  if (SYNC_DEPTH < SYNC_DEPTH_MIN) begin : g_bad_depth
    $error("cdc_ack_sync: SYNC_DEPTH must be >= %0d", SYNC_DEPTH_MIN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_DEPTH-1];

endmodule

// File: rtl/cdc_mcp_src.sv
// Source side of a toggle req/ack multi-cycle-path crossing: holds the word, flips req after
// MCP_DELAY cycles, completes when the synchronized ack matches; s_ready low while a word is in flight.
module cdc_mcp_src
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SYNC_DEPTH = 2,
  parameter int MCP_DELAY  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  output logic [DATA_WIDTH-1:0] o_mcp_data,
  output logic                  o_mcp_req,
  input  logic                  i_mcp_ack,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_proto_err
);

  localparam int                 CNT_W    = $clog2(MCP_DELAY + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MCP_DELAY - 1);

  if (MCP_DELAY < MCP_DELAY_MIN) begin : g_bad_delay
    $error("cdc_mcp_src: MCP_DELAY must be >= %0d", MCP_DELAY_MIN);
  end

  cdc_src_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_mcp_data, w_mcp_data_nxt;
  logic                  r_mcp_req, w_mcp_req_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_proto_err;
  logic                  r_ack_d;
  logic                  w_ack_s;
  logic                  w_ack_edge;

  cdc_ack_sync #(
    .SYNC_DEPTH(SYNC_DEPTH)
  ) u_ack_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_mcp_ack),
    .o_q  (w_ack_s)
  );

  assign w_ack_edge = w_ack_s ^ r_ack_d;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_mcp_data_nxt = r_mcp_data;
    w_mcp_req_nxt  = r_mcp_req;
    w_done_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_s_valid) begin
          w_mcp_data_nxt = i_s_data;
          w_cnt_nxt      = '0;
          w_state_nxt    = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == CNT_LAST) begin
          w_mcp_req_nxt = ~r_mcp_req;
          w_state_nxt   = WAIT_ACK;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT_ACK: begin
        if (w_ack_s == r_mcp_req) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mcp_data  <= '0;
      r_mcp_req   <= 1'b0;
      r_done      <= 1'b0;
      r_proto_err <= 1'b0;
      r_ack_d     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mcp_data  <= w_mcp_data_nxt;
      r_mcp_req   <= w_mcp_req_nxt;
      r_done      <= w_done_nxt;
      r_ack_d     <= w_ack_s;
      // An ack edge is only legitimate while a request is outstanding.
      r_proto_err <= w_ack_edge && (r_state != WAIT_ACK);
    end
  end

  assign o_s_ready   = (r_state == IDLE) && !i_rst;
  assign o_busy      = (r_state != IDLE);
  assign o_mcp_data  = r_mcp_data;
  assign o_mcp_req   = r_mcp_req;
  assign o_done      = r_done;
  assign o_proto_err = r_proto_err;

endmodule
